// File: rtl/fifo_gray_ptr_ctrl.sv
// Single-clock FIFO pointer controller for an external RAM. Keeps binary
// read/write pointers, valid/ready handshakes, occupancy and Gray pointer copies.
module fifo_gray_ptr_ctrl #(
    parameter  int N         = 16,
    parameter  int AF_THRESH = 12,
    localparam int AW        = $clog2(N),
    localparam int PW        = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_vld,
    output logic          push_rdy,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic          ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic [PW-1:0] wr_ptr_gray,
    output logic [PW-1:0] rd_ptr_gray,
    output logic [PW-1:0] count,
    output logic          almost_full
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_gray_q, wr_gray_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic [PW-1:0] count_q, count_d;
    logic          full, empty, push_fire, pop_fire;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // The extra wrap bit distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_rdy  = !full && !flush && !rst;
    assign pop_vld   = !empty && !flush && !rst;
    assign push_fire = push_vld && push_rdy;
    assign pop_fire  = pop_vld && pop_rdy;

    assign ram_wen     = push_fire;
    assign ram_waddr   = wr_ptr_q[AW-1:0];
    assign ram_raddr   = rd_ptr_q[AW-1:0];
    assign wr_ptr_gray = wr_gray_q;
    assign rd_ptr_gray = rd_gray_q;
    assign count       = count_q;
    assign almost_full = (count_q >= PW'(AF_THRESH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + PW'(push_fire) - PW'(pop_fire);
        end
        // Gray copies load from the next pointer so they never lag the binary.
        wr_gray_d = bin2gray(wr_ptr_d);
        rd_gray_d = bin2gray(rd_ptr_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_gray_q <= '0;
            rd_gray_q <= '0;
            count_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_gray_q <= wr_gray_d;
            rd_gray_q <= rd_gray_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// Bench for fifo_gray_ptr_ctrl at N=4, AF_THRESH=3: directed vector table,
// hand-written corner sequences and random traffic against a queue model.
module tb_fifo_gray_ptr_ctrl;
    localparam int N  = 4;
    localparam int AF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0, push_vld = 1'b0, pop_rdy = 1'b0;
    logic       push_rdy, pop_vld, ram_wen, almost_full;
    logic [1:0] ram_waddr, ram_raddr;
    logic [2:0] wr_ptr_gray, rd_ptr_gray, count;

    int errors = 0;
    int checks = 0;

    fifo_gray_ptr_ctrl #(.N(N), .AF_THRESH(AF)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_vld(push_vld), .push_rdy(push_rdy),
        .pop_vld(pop_vld), .pop_rdy(pop_rdy),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: queue of RAM slots holding live entries plus
    // free-running push/pop totals modulo 2N.
    int mq[$];
    int wp = 0, rp = 0;

    task automatic mstep(input logic pv, input logic pr, input logic fl, input string tag);
        logic erdy, epv, pf, of;
        int era;
        @(negedge clk);
        push_vld = pv; pop_rdy = pr; flush = fl;
        #1;
        erdy = (mq.size() < N) && !fl;
        epv  = (mq.size() > 0) && !fl;
        pf   = pv && erdy;
        of   = pr && epv;
        era  = (mq.size() > 0) ? mq[0] : rp % N;
        chk({tag, ".push_rdy"}, 32'(push_rdy), 32'(erdy));
        chk({tag, ".pop_vld"}, 32'(pop_vld), 32'(epv));
        chk({tag, ".ram_wen"}, 32'(ram_wen), 32'(pf));
        chk({tag, ".waddr"}, 32'(ram_waddr), wp % N);
        chk({tag, ".raddr"}, 32'(ram_raddr), era);
        chk({tag, ".wgray"}, 32'(wr_ptr_gray), gray(wp));
        chk({tag, ".rgray"}, 32'(rd_ptr_gray), gray(rp));
        chk({tag, ".count"}, 32'(count), mq.size());
        chk({tag, ".afull"}, 32'(almost_full), 32'(mq.size() >= AF));
        if (fl) begin
            mq.delete();
            wp = 0;
            rp = 0;
        end else begin
            if (pf) begin
                mq.push_back(wp % N);
                wp = (wp + 1) % (2 * N);
            end
            if (of) begin
                void'(mq.pop_front());
                rp = (rp + 1) % (2 * N);
            end
        end
    endtask

    typedef struct {
        logic       pv, pr, fl;
        logic       rdy, pvl, wen;
        logic [1:0] wa, ra;
        logic [2:0] wg, rg, cnt;
        logic       af;
    } vec_t;

    initial begin
        vec_t tbl[17];
        logic [2:0] gseq[8];
        logic [2:0] pwg, prg;
        int pb;

        // Reset held 3 cycles with traffic requested: nothing may fire.
        push_vld = 1'b1; pop_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst.push_rdy", 32'(push_rdy), 0);
            chk("rst.pop_vld", 32'(pop_vld), 0);
            chk("rst.ram_wen", 32'(ram_wen), 0);
        end
        @(negedge clk);
        rst = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0;
        #1;
        chk("rel.push_rdy", 32'(push_rdy), 1);
        chk("rel.pop_vld", 32'(pop_vld), 0);
        chk("rel.count", 32'(count), 0);
        chk("rel.afull", 32'(almost_full), 0);
        chk("rel.wgray", 32'(wr_ptr_gray), 0);
        chk("rel.rgray", 32'(rd_ptr_gray), 0);

        //          pv pr fl  rdy pvl wen  wa ra  wg      rg      cnt af
        tbl[0]  = '{1, 0, 0,  1,  0,  1,   0, 0,  3'b000, 3'b000, 0,  0};
        tbl[1]  = '{1, 0, 0,  1,  1,  1,   1, 0,  3'b001, 3'b000, 1,  0};
        tbl[2]  = '{1, 0, 0,  1,  1,  1,   2, 0,  3'b011, 3'b000, 2,  0};
        tbl[3]  = '{1, 0, 0,  1,  1,  1,   3, 0,  3'b010, 3'b000, 3,  1};
        tbl[4]  = '{1, 0, 0,  0,  1,  0,   0, 0,  3'b110, 3'b000, 4,  1};
        tbl[5]  = '{1, 1, 0,  0,  1,  0,   0, 0,  3'b110, 3'b000, 4,  1};
        tbl[6]  = '{0, 1, 0,  1,  1,  0,   0, 1,  3'b110, 3'b001, 3,  1};
        tbl[7]  = '{0, 1, 0,  1,  1,  0,   0, 2,  3'b110, 3'b011, 2,  0};
        tbl[8]  = '{0, 1, 0,  1,  1,  0,   0, 3,  3'b110, 3'b010, 1,  0};
        tbl[9]  = '{0, 1, 0,  1,  0,  0,   0, 0,  3'b110, 3'b110, 0,  0};
        tbl[10] = '{0, 1, 0,  1,  0,  0,   0, 0,  3'b110, 3'b110, 0,  0};
        tbl[11] = '{1, 0, 0,  1,  0,  1,   0, 0,  3'b110, 3'b110, 0,  0};
        tbl[12] = '{1, 0, 0,  1,  1,  1,   1, 0,  3'b111, 3'b110, 1,  0};
        tbl[13] = '{1, 1, 1,  0,  0,  0,   2, 0,  3'b101, 3'b110, 2,  0};
        tbl[14] = '{0, 0, 0,  1,  0,  0,   0, 0,  3'b000, 3'b000, 0,  0};
        tbl[15] = '{0, 0, 1,  0,  0,  0,   0, 0,  3'b000, 3'b000, 0,  0};
        tbl[16] = '{0, 0, 0,  1,  0,  0,   0, 0,  3'b000, 3'b000, 0,  0};

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            push_vld = tbl[i].pv; pop_rdy = tbl[i].pr; flush = tbl[i].fl;
            #1;
            chk($sformatf("vec%0d.push_rdy", i), 32'(push_rdy), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d.pop_vld", i), 32'(pop_vld), 32'(tbl[i].pvl));
            chk($sformatf("vec%0d.ram_wen", i), 32'(ram_wen), 32'(tbl[i].wen));
            chk($sformatf("vec%0d.waddr", i), 32'(ram_waddr), 32'(tbl[i].wa));
            chk($sformatf("vec%0d.raddr", i), 32'(ram_raddr), 32'(tbl[i].ra));
            chk($sformatf("vec%0d.wgray", i), 32'(wr_ptr_gray), 32'(tbl[i].wg));
            chk($sformatf("vec%0d.rgray", i), 32'(rd_ptr_gray), 32'(tbl[i].rg));
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.afull", i), 32'(almost_full), 32'(tbl[i].af));
        end

        // Steady push+pop after one pre-fill entry: Gray codes walk the cycle.
        gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        mstep(1'b1, 1'b0, 1'b0, "prefill");
        pwg = '0; prg = '0;
        for (int i = 0; i < 20; i++) begin
            mstep(1'b1, 1'b1, 1'b0, "stream");
            chk("stream.wseq", 32'(wr_ptr_gray), 32'(gseq[(i + 1) % 8]));
            chk("stream.rseq", 32'(rd_ptr_gray), 32'(gseq[i % 8]));
            if (i > 0) begin
                chk("stream.wflip", $countones(wr_ptr_gray ^ pwg), 1);
                chk("stream.rflip", $countones(rd_ptr_gray ^ prg), 1);
            end
            pwg = wr_ptr_gray;
            prg = rd_ptr_gray;
        end

        // Random traffic with alternating fill/drain bias and rare flushes.
        for (int i = 0; i < 400; i++) begin
            pb = ((i / 50) % 2 == 0) ? 75 : 30;
            mstep(logic'($urandom_range(0, 99) < pb),
                  logic'($urandom_range(0, 99) < 100 - pb),
                  logic'($urandom_range(0, 39) == 0), "rand");
        end

        // Asynchronous reset mid-cycle with two entries held and a push pending.
        mstep(1'b0, 1'b0, 1'b1, "pre6");
        mstep(1'b1, 1'b0, 1'b0, "pre6");
        mstep(1'b1, 1'b0, 1'b0, "pre6");
        @(negedge clk);
        push_vld = 1'b1; pop_rdy = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.push_rdy", 32'(push_rdy), 0);
        chk("arst.pop_vld", 32'(pop_vld), 0);
        chk("arst.ram_wen", 32'(ram_wen), 0);
        chk("arst.count", 32'(count), 0);
        chk("arst.wgray", 32'(wr_ptr_gray), 0);
        chk("arst.rgray", 32'(rd_ptr_gray), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; push_vld = 1'b0;
        #1;
        chk("arel.push_rdy", 32'(push_rdy), 1);
        chk("arel.pop_vld", 32'(pop_vld), 0);
        chk("arel.count", 32'(count), 0);
        chk("arel.wgray", 32'(wr_ptr_gray), 0);
        chk("arel.rgray", 32'(rd_ptr_gray), 0);
        mq.delete();
        wp = 0;
        rp = 0;
        mstep(1'b1, 1'b0, 1'b0, "post");
        mstep(1'b0, 1'b1, 1'b0, "post");
        mstep(1'b0, 1'b0, 1'b0, "post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
